// File: rtl/systolic_pkg.sv
// Shared types and default sizing for the systolic array result path.
// Holds the output buffer FSM encoding and an index-width helper.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } obuf_state_t;

  localparam int OBUF_COLS       = 4;
  localparam int OBUF_ROWS       = 64;
  localparam int OBUF_DATA_WIDTH = 32;

  // Width needed to index n entries; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/output_buffer_c_if.sv
// Capture/drain bus of the output buffer: per-lane capture strobes, the
// row-major drain stream, and status.
interface output_buffer_c_if #(
   parameter int COLS       = systolic_pkg::OBUF_COLS,
   parameter int DATA_WIDTH = systolic_pkg::OBUF_DATA_WIDTH
);

   logic                       start;
   logic [COLS-1:0]            in_valid;
   logic [COLS*DATA_WIDTH-1:0] in_data;

   // Drain stream: an element transfers on every cycle with out_valid && out_ready;
   // while out_valid && !out_ready, out_data and out_last hold; out_valid never
   // drops before its transfer completes.
   logic                       out_valid;
   logic                       out_ready;
   logic [DATA_WIDTH-1:0]      out_data;
   logic                       out_last;

   logic                       busy;
   logic                       done;
   logic                       overflow;

   modport master (
      output start, in_valid, in_data, out_ready,
      input  out_valid, out_data, out_last, busy, done, overflow
   );

   modport slave (
      input  start, in_valid, in_data, out_ready,
      output out_valid, out_data, out_last, busy, done, overflow
   );

endinterface

// File: rtl/obuf_lane.sv
// One capture lane of the output buffer: ROWS-deep storage written in
// arrival order, with a fill counter and an asynchronous read port.
module obuf_lane
   import systolic_pkg::*;
#(
   parameter int ROWS       = OBUF_ROWS,
   parameter int DATA_WIDTH = OBUF_DATA_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [DATA_WIDTH-1:0]    wr_data,
   input  logic                     clr,
   input  logic [idx_w(ROWS)-1:0]   rd_idx,
   output logic                     lane_full,
   output logic                     lane_last_wr,
   output logic [DATA_WIDTH-1:0]    rd_data
);

   localparam int FILL_W = $clog2(ROWS + 1);
   localparam int ROW_W  = idx_w(ROWS);

   logic [FILL_W-1:0]     fill_q;
   logic [DATA_WIDTH-1:0] mem [ROWS];
   logic                  accept;

   assign lane_full    = (fill_q == FILL_W'(ROWS));
   assign accept       = wr_en && !lane_full;
   // Flags the write that completes this lane, so the top can leave CAPTURE
   // on the same edge.
   assign lane_last_wr = accept && (fill_q == FILL_W'(ROWS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill_q <= '0;
      end else if (clr) begin
         fill_q <= '0;
      end else if (accept) begin
         fill_q <= fill_q + FILL_W'(1);
      end
   end

   // Storage is not reset; contents are only meaningful once the lane is full.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem[fill_q[ROW_W-1:0]] <= wr_data;
      end
   end

   assign rd_data = mem[rd_idx];

endmodule

// File: rtl/output_buffer_c.sv
// Systolic array output buffer: per-column skewed capture, then row-major drain.
// Define OBUF_OVERFLOW_DET_EN to build the sticky overflow detector.
module output_buffer_c
   import systolic_pkg::*;
#(
   parameter int COLS       = OBUF_COLS,
   parameter int ROWS       = OBUF_ROWS,
   parameter int DATA_WIDTH = OBUF_DATA_WIDTH
) (
   input  logic                clk,
   input  logic                rst_n,
   output_buffer_c_if.slave    bus,
   output obuf_state_t         state_dbg
);

   localparam int K_W   = idx_w(ROWS * COLS);
   localparam int ROW_W = idx_w(ROWS);
   localparam int COL_W = idx_w(COLS);
   localparam logic [K_W-1:0] K_LAST = K_W'(ROWS * COLS - 1);

   obuf_state_t           state_q, state_d;
   logic [K_W-1:0]        k_q;
   logic [ROW_W-1:0]      drain_row;
   logic [COL_W-1:0]      drain_col;
   logic                  capture, draining;
   logic                  hs, last_hs, all_full_next;
   logic                  done_q;
   logic [COLS-1:0]       wr_en, lane_full, lane_last_wr;
   logic [DATA_WIDTH-1:0] lane_rd [COLS];

   assign capture  = (state_q == CAPTURE);
   assign draining = (state_q == DRAIN);
   assign wr_en    = {COLS{capture}} & bus.in_valid;

   // Flat drain index k = row*COLS + col, column fastest.
   assign drain_row = ROW_W'(32'(k_q) / COLS);
   assign drain_col = COL_W'(32'(k_q) % COLS);

   assign hs      = draining && bus.out_ready;
   assign last_hs = hs && (k_q == K_LAST);

   // A lane counts as full if it already is, or its last write lands this edge.
   assign all_full_next = &(lane_full | lane_last_wr);

   for (genvar c = 0; c < COLS; c++) begin : g_lane
      obuf_lane #(
         .ROWS       (ROWS),
         .DATA_WIDTH (DATA_WIDTH)
      ) u_lane (
         .clk          (clk),
         .rst_n        (rst_n),
         .wr_en        (wr_en[c]),
         .wr_data      (bus.in_data[c*DATA_WIDTH +: DATA_WIDTH]),
         .clr          (last_hs),
         .rd_idx       (drain_row),
         .lane_full    (lane_full[c]),
         .lane_last_wr (lane_last_wr[c]),
         .rd_data      (lane_rd[c])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start)    state_d = CAPTURE;
         CAPTURE: if (all_full_next) state_d = DRAIN;
         DRAIN:   if (last_hs)      state_d = IDLE;
         default:                   state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k_q    <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= last_hs;
         if (last_hs) begin
            k_q <= '0;
         end else if (hs) begin
            k_q <= k_q + K_W'(1);
         end
      end
   end

   assign bus.out_valid = draining;
   assign bus.out_last  = draining && (k_q == K_LAST);
   assign bus.out_data  = draining ? lane_rd[drain_col] : '0;
   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = done_q;
   assign state_dbg     = state_q;

`ifdef OBUF_OVERFLOW_DET_EN
   logic            ovf_q;
   logic [COLS-1:0] drop;

   // A drop is a capture strobe aimed at a lane that already holds ROWS results.
   assign drop = wr_en & lane_full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if ((state_q == IDLE) && bus.start) begin
         ovf_q <= 1'b0;
      end else if (|drop) begin
         ovf_q <= 1'b1;
      end
   end

   assign bus.overflow = ovf_q;
`else
   assign bus.overflow = 1'b0;
`endif

endmodule
